// File: rtl/ntt_loop_controller_pkg.sv
// rtl/ntt_loop_controller_pkg.sv - shared constants, state type and stage-bound lookups for the NTT sequencer
package ntt_loop_controller_pkg;

  localparam int N               = 512;
  localparam logic [2:0] P_MAX   = 3'd4;
  localparam int BEATS_PER_STAGE = N / 4;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  // Last intra-group index of a radix-4 stage: 4^p - 1
  function automatic logic [6:0] jmax(input logic [2:0] p);
    case (p)
      3'd3:    jmax = 7'd63;
      3'd2:    jmax = 7'd15;
      3'd1:    jmax = 7'd3;
      default: jmax = 7'd0;
    endcase
  endfunction

  // Last group index of a radix-4 stage: 128/4^p - 1
  function automatic logic [6:0] kmax(input logic [2:0] p);
    case (p)
      3'd3:    kmax = 7'd1;
      3'd2:    kmax = 7'd7;
      3'd1:    kmax = 7'd31;
      3'd0:    kmax = 7'd127;
      default: kmax = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/ntt_loop_controller_if.sv
// rtl/ntt_loop_controller_if.sv - index tuple stream from the sequencer to the address generator
interface ntt_loop_controller_if;
  logic       valid;
  logic       ready;
  logic [6:0] i;
  logic [6:0] k;
  logic [6:0] j;
  logic [2:0] p;
  logic       stage_last;

  modport master (output valid, output i, output k, output j, output p, output stage_last, input ready);
  modport slave  (input valid, input i, input k, input j, input p, input stage_last, output ready);
endinterface

// File: rtl/ntt_loop_controller_stage_counter.sv
// rtl/ntt_loop_controller_stage_counter.sv - nested i / k,j index counter for one NTT stage
module ntt_loop_controller_stage_counter
  import ntt_loop_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] p,
  output logic [6:0] i,
  output logic [6:0] k,
  output logic [6:0] j,
  output logic       stage_last,
  output logic       stage_end
);

  localparam logic [6:0] I_LAST = 7'(BEATS_PER_STAGE - 1);

  // Decode the final tuple of the current stage
  always_comb begin
    stage_last = 1'b0;
    if (p == P_MAX) stage_last = (i == I_LAST);
    else            stage_last = (k == kmax(p)) && (j == jmax(p));
  end

  assign stage_end = en & stage_last;

  // Advance on each accepted beat; stage end clears all indices for the next stage
  always_ff @(posedge clk) begin
    if (rst) begin
      i <= '0;
      k <= '0;
      j <= '0;
    end else if (en) begin
      if (stage_last) begin
        i <= '0;
        k <= '0;
        j <= '0;
      end else if (p == P_MAX) begin
        i <= i + 7'd1;
      end else if (j == jmax(p)) begin
        j <= '0;
        k <= k + 7'd1;
      end else begin
        j <= j + 7'd1;
      end
    end
  end

endmodule

// File: rtl/ntt_loop_controller.sv
// rtl/ntt_loop_controller.sv - stage/loop sequencer for the 512-point mixed-radix NTT
module ntt_loop_controller
  import ntt_loop_controller_pkg::*;
#(
  parameter int STAGE_GAP = 8,
  parameter int GAP_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  ntt_loop_controller_if.master bus
);

  localparam logic [GAP_W-1:0] GAP_LAST = (STAGE_GAP == 0) ? '0 : GAP_W'(STAGE_GAP - 1);

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [2:0]       p;
  logic             valid;
  logic             accept;
  logic             stage_last_raw;
  logic             stage_end;

  // valid depends only on state, so ready never reaches valid combinationally
  assign accept         = valid & bus.ready;
  assign bus.valid      = valid;
  assign bus.p          = p;
  assign bus.stage_last = valid & stage_last_raw;

  ntt_loop_controller_stage_counter u_counter (
    .clk        (clk),
    .rst        (rst),
    .en         (accept),
    .p          (p),
    .i          (bus.i),
    .k          (bus.k),
    .j          (bus.j),
    .stage_last (stage_last_raw),
    .stage_end  (stage_end)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        valid = 1'b1;
        if (stage_end) begin
          if (p == 3'd0)          state_nxt = DONE;
          else if (STAGE_GAP > 0) state_nxt = GAP;
          else                    state_nxt = RUN;
        end
      end
      GAP:  if (gap_cnt == GAP_LAST) state_nxt = RUN;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage number: step down at each stage end, reload for the next transform in DONE
  always_ff @(posedge clk) begin
    if (rst)                          p <= P_MAX;
    else if (state == DONE)           p <= P_MAX;
    else if (stage_end && p != 3'd0)  p <= p - 3'd1;
  end

  // Drain gap counter, only runs while in GAP
  always_ff @(posedge clk) begin
    if (rst || state != GAP)    gap_cnt <= '0;
    else if (gap_cnt == GAP_LAST) gap_cnt <= '0;
    else                        gap_cnt <= gap_cnt + 1'b1;
  end

endmodule

// File: tb/tb_ntt_loop_controller.sv
// tb/tb_ntt_loop_controller.sv - directed self-checking bench for ntt_loop_controller
module tb_ntt_loop_controller;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic ready;
  logic busy8, done8, busy0, done0;

  int vectors = 0;
  int errors  = 0;

  logic [6:0] exp_i [640];
  logic [6:0] exp_k [640];
  logic [6:0] exp_j [640];
  logic [2:0] exp_p [640];
  logic       exp_last [640];

  ntt_loop_controller_if bus8 ();
  ntt_loop_controller_if bus0 ();

  assign bus8.ready = ready;
  assign bus0.ready = ready;

  ntt_loop_controller #(.STAGE_GAP(8), .GAP_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(start), .busy(busy8), .done(done8), .bus(bus8)
  );

  ntt_loop_controller #(.STAGE_GAP(0), .GAP_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0), .bus(bus0)
  );

  always #5 clk = ~clk;

  task automatic build_model();
    int n;
    n = 0;
    for (int a = 0; a < 128; a++) begin
      exp_p[n] = 3'd4; exp_i[n] = a[6:0]; exp_k[n] = '0; exp_j[n] = '0;
      exp_last[n] = (a == 127);
      n++;
    end
    for (int s = 3; s >= 0; s--) begin
      int jn;
      int kn;
      jn = 1 << (2 * s);
      kn = 128 / jn;
      for (int kk = 0; kk < kn; kk++) begin
        for (int jj = 0; jj < jn; jj++) begin
          exp_p[n] = s[2:0]; exp_i[n] = '0; exp_k[n] = kk[6:0]; exp_j[n] = jj[6:0];
          exp_last[n] = (kk == kn - 1) && (jj == jn - 1);
          n++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus8.valid, bus8.stage_last, busy8, done8, bus8.p, bus8.i, bus8.k, bus8.j} !== {4'b0, 3'd4, 21'd0}) begin
      errors++;
      $display("FAIL reset_gap8 got v=%b sl=%b busy=%b done=%b p=%0d i=%0d k=%0d j=%0d want all 0 with p=4",
               bus8.valid, bus8.stage_last, busy8, done8, bus8.p, bus8.i, bus8.k, bus8.j);
    end
    vectors++;
    if ({bus0.valid, bus0.stage_last, busy0, done0, bus0.p, bus0.i, bus0.k, bus0.j} !== {4'b0, 3'd4, 21'd0}) begin
      errors++;
      $display("FAIL reset_gap0 got v=%b busy=%b p=%0d want v=0 busy=0 p=4", bus0.valid, busy0, bus0.p);
    end
  endtask

  // Full transform on dut8; with timing=1 ready stays high and cycle-exact checks run on both instances
  task automatic test_full_run(input bit rand_ready, input bit timing);
    int beat, done_cnt, done_cyc, last_cyc, valid0_cnt, done0_cyc, last_cnt;
    bit stalled;
    logic [24:0] held;
    beat = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1; valid0_cnt = 0; done0_cyc = -1;
    last_cnt = 0; stalled = 1'b0; held = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        vectors++;
        if ({bus8.p, bus8.i, bus8.k, bus8.j, bus8.stage_last} !== held) begin
          errors++;
          $display("FAIL stall_hold cycle %0d got %h want %h", cyc,
                   {bus8.p, bus8.i, bus8.k, bus8.j, bus8.stage_last}, held);
        end
      end
      stalled = 1'b0;
      if (bus8.valid && ready) begin
        vectors++;
        if (beat >= 640) begin
          errors++;
          $display("FAIL extra_beat got beat %0d want at most 640 beats", beat + 1);
        end else if ({bus8.p, bus8.i, bus8.k, bus8.j, bus8.stage_last} !==
                     {exp_p[beat], exp_i[beat], exp_k[beat], exp_j[beat], exp_last[beat]}) begin
          errors++;
          $display("FAIL sequence beat %0d got p=%0d i=%0d k=%0d j=%0d sl=%b want p=%0d i=%0d k=%0d j=%0d sl=%b",
                   beat, bus8.p, bus8.i, bus8.k, bus8.j, bus8.stage_last,
                   exp_p[beat], exp_i[beat], exp_k[beat], exp_j[beat], exp_last[beat]);
        end
        if (bus8.stage_last) last_cnt++;
        beat++;
        last_cyc = cyc;
      end else if (bus8.valid) begin
        stalled = 1'b1;
        held = {bus8.p, bus8.i, bus8.k, bus8.j, bus8.stage_last};
      end
      if (done8) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (timing) begin
        if (cyc <= 660 && bus0.valid) valid0_cnt++;
        if (done0 && done0_cyc < 0) done0_cyc = cyc;
        if (cyc == 128) begin
          vectors++;
          if ({bus0.valid, bus0.p, bus0.i, bus0.stage_last} !== {1'b1, 3'd4, 7'd127, 1'b1}) begin
            errors++;
            $display("FAIL gap0_stage4_end got v=%b p=%0d i=%0d sl=%b want v=1 p=4 i=127 sl=1",
                     bus0.valid, bus0.p, bus0.i, bus0.stage_last);
          end
        end
        if (cyc == 129) begin
          vectors++;
          if ({bus0.valid, bus0.p, bus0.k, bus0.j} !== {1'b1, 3'd3, 7'd0, 7'd0}) begin
            errors++;
            $display("FAIL gap0_stage3_start got v=%b p=%0d k=%0d j=%0d want v=1 p=3 k=0 j=0",
                     bus0.valid, bus0.p, bus0.k, bus0.j);
          end
        end
        if (cyc == 674 || cyc == 675) begin
          vectors++;
          if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_ignored cycle %0d got busy=%b want 0", cyc, busy8);
          end
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3 && (!timing || cyc >= 676)) break;
      @(posedge clk);
      #1;
      start = timing && (cyc == 49 || cyc == 672);
      ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
    start = 1'b0;
    ready = 1'b1;
    vectors++;
    if (beat !== 640) begin
      errors++;
      $display("FAIL beat_count got %0d want 640", beat);
    end
    vectors++;
    if (last_cnt !== 5) begin
      errors++;
      $display("FAIL stage_last_count got %0d want 5", last_cnt);
    end
    vectors++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL done_pulses got %0d want 1", done_cnt);
    end
    if (timing) begin
      vectors++;
      if (last_cyc !== 672) begin
        errors++;
        $display("FAIL last_beat_cycle got %0d want 672", last_cyc);
      end
      vectors++;
      if (done_cyc !== 673) begin
        errors++;
        $display("FAIL done_cycle got %0d want 673", done_cyc);
      end
      vectors++;
      if (done0_cyc !== 641) begin
        errors++;
        $display("FAIL gap0_done_cycle got %0d want 641", done0_cyc);
      end
      vectors++;
      if (valid0_cnt !== 640) begin
        errors++;
        $display("FAIL gap0_valid_cycles got %0d want 640", valid0_cnt);
      end
    end
  endtask

  task automatic test_rst_mid();
    int beat;
    bit hit;
    beat = 0;
    hit = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ready = 1'b1;
    for (int cyc = 1; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (bus8.valid && ready) begin
        if (beat == 300) hit = 1'b1;
        beat++;
      end
      if (hit) break;
      @(posedge clk);
    end
    vectors++;
    if (!hit) begin
      errors++;
      $display("FAIL rst_mid_reach got %0d beats want beat 300 reached", beat);
    end else begin
      vectors++;
      if ({bus8.p, bus8.k, bus8.j} !== {3'd2, 7'd2, 7'd12}) begin
        errors++;
        $display("FAIL beat300_tuple got p=%0d k=%0d j=%0d want p=2 k=2 j=12", bus8.p, bus8.k, bus8.j);
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus8.valid, busy8, done8, bus8.p, bus8.i, bus8.k, bus8.j} !== {3'b0, 3'd4, 21'd0}) begin
        errors++;
        $display("FAIL rst_mid_state got v=%b busy=%b done=%b p=%0d i=%0d k=%0d j=%0d want idle p=4 indices 0",
                 bus8.valid, busy8, done8, bus8.p, bus8.i, bus8.k, bus8.j);
      end
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        vectors++;
        if ({bus8.valid, busy8, done8} !== 3'b000) begin
          errors++;
          $display("FAIL rst_mid_quiet cycle %0d got v=%b busy=%b done=%b want 000", c, bus8.valid, busy8, done8);
        end
      end
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_full_run(1'b0, 1'b1);
    test_full_run(1'b1, 1'b0);
    test_rst_mid();
    test_full_run(1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
